// File: rtl/if_fetch_unit_pkg.sv
// Shared RISC-V fetch definitions: reset PC, NOP encoding and fetch FSM states.
package if_fetch_unit_pkg;

  // Canonical NOP (addi x0, x0, 0) offered whenever no instruction is valid
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // Default first fetch address after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch FSM: at most one memory request is ever outstanding
  typedef enum logic [1:0] {
    S_REQ     = 2'b00,  // presenting a request at fetch_pc
    S_WAIT    = 2'b01,  // request accepted, waiting for the response
    S_HOLD    = 2'b10,  // response parked in the hold buffer while stalled
    S_DISCARD = 2'b11   // redirected while waiting; next response is stale
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_pc_gen.sv
// Next fetch-PC selection: redirect target (word aligned), PC+4, or hold.
module if_pc_gen #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                advance,
  output logic [PC_WIDTH-1:0] next_pc
);

  // Clearing the two low bits word-aligns the redirect target
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(2'b11);

  logic [PC_WIDTH-1:0] pc_plus4_s;

  // Sequential increment wraps naturally modulo 2^PC_WIDTH
  assign pc_plus4_s = fetch_pc + PC_WIDTH'(3'd4);

  // Redirect has priority over sequential advance
  always_comb begin
    next_pc = fetch_pc;
    if (branch_taken) begin
      next_pc = branch_target & ALIGN_MASK;
    end else if (advance) begin
      next_pc = pc_plus4_s;
    end else begin
      next_pc = fetch_pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single-outstanding request/response fetch with
// stall hold buffer and branch redirect/flush handling.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                PC_WIDTH   = 32,
  parameter int                INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pc_write,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  IF_flush
);

  localparam logic [INST_WIDTH-1:0] NOP_WORD = INST_WIDTH'(NOP_INST);

  fetch_state_e          state_r;
  fetch_state_e          state_next_s;
  logic [PC_WIDTH-1:0]   fetch_pc_r;
  logic [PC_WIDTH-1:0]   next_pc_s;
  logic [INST_WIDTH-1:0] hold_inst_r;
  logic                  advance_s;
  logic                  hold_load_s;

  if_pc_gen #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_gen (
    .fetch_pc      (fetch_pc_r),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .advance       (advance_s),
    .next_pc       (next_pc_s)
  );

  // The flush request follows the redirect combinationally
  assign IF_flush      = branch_taken;
  assign imem_req_addr = fetch_pc_r;

  // State, fetch PC and hold buffer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= S_REQ;
      fetch_pc_r  <= RESET_PC;
      hold_inst_r <= NOP_WORD;
    end else begin
      state_r    <= state_next_s;
      fetch_pc_r <= next_pc_s;
      if (hold_load_s) begin
        hold_inst_r <= imem_rsp_data;
      end
    end
  end

  // Next-state and output decode; redirect always beats a stall
  always_comb begin
    state_next_s   = state_r;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    inst           = NOP_WORD;
    pc             = fetch_pc_r;
    advance_s      = 1'b0;
    hold_load_s    = 1'b0;
    if (!reset_n) begin
      // Nothing is delivered or requested while reset is applied
      state_next_s = S_REQ;
      pc           = RESET_PC;
    end else begin
      case (state_r)
        S_REQ: begin
          if (branch_taken) begin
            // Retarget: never issue at the stale address
            state_next_s = S_REQ;
          end else begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
              state_next_s = S_WAIT;
            end else begin
              state_next_s = S_REQ;
            end
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (branch_taken) begin
              // Response belongs to the wrong path: drop it
              state_next_s = S_REQ;
            end else begin
              inst_valid = 1'b1;
              inst       = imem_rsp_data;
              if (pc_write) begin
                advance_s    = 1'b1;
                state_next_s = S_REQ;
              end else begin
                hold_load_s  = 1'b1;
                state_next_s = S_HOLD;
              end
            end
          end else if (branch_taken) begin
            state_next_s = S_DISCARD;
          end else begin
            state_next_s = S_WAIT;
          end
        end
        S_HOLD: begin
          inst_valid = 1'b1;
          inst       = hold_inst_r;
          if (branch_taken) begin
            state_next_s = S_REQ;
          end else if (pc_write) begin
            advance_s    = 1'b1;
            state_next_s = S_REQ;
          end else begin
            state_next_s = S_HOLD;
          end
        end
        S_DISCARD: begin
          // A further redirect only updates fetch_pc via the PC mux
          if (imem_rsp_valid) begin
            state_next_s = S_REQ;
          end else begin
            state_next_s = S_DISCARD;
          end
        end
        default: begin
          state_next_s = S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: behavioural memory plus a
// scoreboard of accepted requests compared against delivered instructions.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        IF_flush;

  if_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_write       (pc_write),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .IF_flush       (IF_flush)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          stale;
  } item_t;

  item_t       sb_q[$];
  logic [31:0] acc_log[$];
  item_t       hold_item;
  bit          holding;
  logic [31:0] exp_fetch;
  int          delivered;
  int          req_seen;

  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          rsp_delay;
  bit          keep_late;

  logic        last_req_valid;
  logic [31:0] last_req_addr;
  logic        last_inst_valid;
  logic [31:0] last_inst;
  logic        last_flush;

  int n_checks;
  int n_pass;
  int a0;
  int d0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0050_0093;
    return a ^ 32'h1234_5000;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock cycle: present memory response, check outputs, advance models
  task automatic step();
    item_t it;
    bit    exp_v;
    @(negedge clk);
    imem_rsp_valid = pend && (pend_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_data(pend_addr) : 32'hDEAD_BEEF;
    #1;
    last_req_valid  = imem_req_valid;
    last_req_addr   = imem_req_addr;
    last_inst_valid = inst_valid;
    last_inst       = inst;
    last_flush      = IF_flush;
    if (imem_req_valid) req_seen++;
    check_value("flush", IF_flush, branch_taken);
    if (!reset_n) begin
      check_value("rst_inst_valid", inst_valid, 1'b0);
      check_value("rst_inst", inst, NOP);
      check_value("rst_pc", pc, RESET_PC);
    end else begin
      if (branch_taken) check_value("retarget_no_req", imem_req_valid, 1'b0);
      if (sb_q.size() != 0 || holding) check_value("one_outstanding", imem_req_valid, 1'b0);
      if (imem_req_valid) check_value("req_addr", imem_req_addr, exp_fetch);
      exp_v = 1'b0;
      it    = hold_item;
      if (holding) begin
        exp_v = 1'b1;
      end else if (imem_rsp_valid && sb_q.size() != 0) begin
        it    = sb_q.pop_front();
        exp_v = !(it.stale || branch_taken);
      end
      check_value("inst_valid", inst_valid, exp_v);
      if (exp_v) begin
        check_value("pc", pc, it.addr);
        check_value("inst", inst, it.data);
      end else begin
        check_value("inst_nop", inst, NOP);
      end
      if (branch_taken) begin
        exp_fetch = branch_target & 32'hFFFF_FFFC;
        foreach (sb_q[i]) sb_q[i].stale = 1'b1;
        holding = 1'b0;
      end else if (exp_v && pc_write) begin
        exp_fetch = exp_fetch + 32'd4;
        holding   = 1'b0;
        delivered++;
      end else if (exp_v) begin
        holding   = 1'b1;
        hold_item = it;
      end
    end
    @(posedge clk);
    if (imem_rsp_valid) pend = 1'b0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (!reset_n) begin
      sb_q.delete();
      holding   = 1'b0;
      exp_fetch = RESET_PC;
      if (!keep_late) pend = 1'b0;
    end else if (last_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_cnt  = rsp_delay;
      pend_addr = last_req_addr;
      sb_q.push_back('{addr: last_req_addr, data: mem_data(last_req_addr), stale: 1'b0});
      acc_log.push_back(last_req_addr);
    end
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; delivered = 0; req_seen = 0;
    reset_n = 1'b0; pc_write = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0; rsp_delay = 0; keep_late = 1'b0;
    holding = 1'b0; exp_fetch = RESET_PC;

    // Reset, including a redirect while in reset
    step();
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    step();
    branch_taken = 1'b0;
    reset_n = 1'b1;

    // Straight-line fetch, always-ready memory, 1-cycle response
    step();
    check_value("first_req_valid", last_req_valid, 1'b1);
    check_value("first_req_addr", last_req_addr, RESET_PC);
    for (int i = 0; i < 30 && delivered < 3; i++) step();
    check_value("seq_delivered", delivered, 3);
    check_value("seq_addr0", acc_log[0], 32'h0);
    check_value("seq_addr1", acc_log[1], 32'h4);
    check_value("seq_addr2", acc_log[2], 32'h8);

    // Stall for three cycles with a response arriving in WAIT
    for (int i = 0; i < 10 && sb_q.size() == 0; i++) step();
    check_value("stall_accepted", sb_q.size(), 1);
    pc_write = 1'b0; req_seen = 0; d0 = delivered;
    repeat (3) step();
    check_value("stall_no_req", req_seen, 0);
    check_value("stall_valid", last_inst_valid, 1'b1);
    check_value("stall_inst", last_inst, 32'h0050_0093);
    pc_write = 1'b1;
    step();
    check_value("stall_release", delivered, d0 + 1);

    // Redirect in WAIT, stale response two cycles later
    rsp_delay = 2;
    for (int i = 0; i < 10 && sb_q.size() == 0; i++) step();
    check_value("br_wait_accepted", sb_q.size(), 1);
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    step();
    check_value("br_wait_flush", last_flush, 1'b1);
    branch_taken = 1'b0; rsp_delay = 0;
    a0 = acc_log.size();
    for (int i = 0; i < 20 && acc_log.size() == a0; i++) step();
    check_value("br_wait_next_req", acc_log[$], 32'h0000_0100);

    // Redirect coinciding with the response
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    step();
    check_value("br_rsp_drop", last_inst_valid, 1'b0);
    branch_taken = 1'b0;
    a0 = acc_log.size();
    for (int i = 0; i < 20 && acc_log.size() == a0; i++) step();
    check_value("br_rsp_next_req", acc_log[$], 32'h0000_0200);

    // Redirect in REQ to the top of the address space, then wrap
    step();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    check_value("retarget_req", last_req_valid, 1'b0);
    branch_taken = 1'b0;
    a0 = acc_log.size();
    for (int i = 0; i < 20 && acc_log.size() == a0; i++) step();
    check_value("wrap_top_req", acc_log[$], 32'hFFFF_FFFC);
    a0 = acc_log.size();
    for (int i = 0; i < 20 && acc_log.size() == a0; i++) step();
    check_value("wrap_next_req", acc_log[$], 32'h0000_0000);

    // Reset mid-WAIT with a late response afterwards
    rsp_delay = 3;
    for (int i = 0; i < 20 && !(pend && pend_cnt == 3); i++) step();
    check_value("rst_wait_accepted", pend_cnt, 3);
    step();
    reset_n = 1'b0; keep_late = 1'b1;
    step();
    reset_n = 1'b1; imem_req_ready = 1'b0;
    step();
    check_value("post_rst_req_valid", last_req_valid, 1'b1);
    check_value("post_rst_req_addr", last_req_addr, RESET_PC);
    step();
    check_value("late_rsp_ignored", last_inst_valid, 1'b0);
    keep_late = 1'b0; imem_req_ready = 1'b1; rsp_delay = 0;
    a0 = acc_log.size();
    for (int i = 0; i < 20 && acc_log.size() == a0; i++) step();
    check_value("post_rst_accept", acc_log[$], RESET_PC);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
